// File: rtl/rle_block_builder_if.sv
// Symbol-in / block-out bus of rle_block_builder.
// The master modport drives symbols and row acceptance; the slave modport is the block builder.
interface rle_block_builder_if #(
  parameter int COEF_W = 8,
  parameter int ADDR_W = 15
);
  logic                 in_valid;
  logic                 in_ready;
  logic [5:0]           in_run;
  logic [COEF_W-1:0]    in_level;
  logic                 in_eob;
  logic [64*COEF_W-1:0] blk_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_W-1:0]    out_addr;
  logic                 out_err;

  modport master (
    output in_valid, in_run, in_level, in_eob, out_ready,
    input  in_ready, blk_data, out_valid, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_run, in_level, in_eob, out_ready,
    output in_ready, blk_data, out_valid, out_addr, out_err
  );
endinterface

// File: rtl/rle_block_builder.sv
// Builds a 64-entry zigzag-ordered coefficient block from run-length symbols, then steps 8 row addresses.
// Optional DC prediction on index 0 is enabled by defining RLB_DC_PRED_EN.
module rle_block_builder #(
  parameter int COEF_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  rle_block_builder_if.slave bus
);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [COEF_W-1:0] buffer [64];
  logic [6:0]        pos;
  logic [2:0]        row;
  logic              err;
  logic [6:0]        idx;
  logic              accept;
  logic              handshake;
  logic              enter_drain;
  logic [COEF_W-1:0] wr_level;

  assign accept      = (state == FILL) && bus.in_valid;
  assign handshake   = (state == DRAIN) && bus.out_ready;
  assign idx         = pos + {1'b0, bus.in_run};
  assign enter_drain = accept && (bus.in_eob || (idx >= 7'd63));

`ifdef RLB_DC_PRED_EN
  logic [COEF_W-1:0] dc_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_prev <= '0;
    end else if (enter_drain) begin
      dc_prev <= buffer[0];
    end
  end

  assign wr_level = (idx == 7'd0) ? (bus.in_level + dc_prev) : bus.in_level;
`else
  assign wr_level = bus.in_level;
`endif

  // The buffer is wiped on the final row handshake, so blk_data already reads
  // cleared during the CLEAR bubble; CLEAR itself only hands control back to FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      pos   <= '0;
      row   <= '0;
      err   <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      case (state)
        CLEAR: begin
          state <= FILL;
        end
        FILL: begin
          if (accept) begin
            if (bus.in_eob) begin
              state <= DRAIN;
            end else if (idx <= 7'd63) begin
              buffer[idx[5:0]] <= wr_level;
              pos              <= idx + 7'd1;
              if (idx == 7'd63) begin
                state <= DRAIN;
              end
            end else begin
              err   <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (row == 3'd7) begin
              row   <= '0;
              pos   <= '0;
              err   <= 1'b0;
              state <= CLEAR;
              for (int i = 0; i < 64; i++) begin
                buffer[i] <= '0;
              end
`ifdef RLB_DC_PRED_EN
              buffer[0] <= dc_prev;
`endif
            end else begin
              row <= row + 3'd1;
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_err   = err;
  // Rows are offered starting at code 4 so the downstream zigzag stage sees 4..7 then 0..3.
  assign bus.out_addr  = (state == DRAIN) ? {{(ADDR_W-3){1'b0}}, row + 3'd4} : '0;

  for (genvar g = 0; g < 64; g++) begin : g_pack
    assign bus.blk_data[(63-g)*COEF_W +: COEF_W] = buffer[g];
  end

endmodule

// File: tb/tb_rle_block_builder.sv
// Directed bench for rle_block_builder: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_rle_block_builder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [7:0]   exp_buf [64];
  logic [7:0]   dc_model;
  logic [511:0] blk_a;
  logic [511:0] clr_blk;

  typedef struct {
    logic       vld;
    logic [5:0] run;
    logic [7:0] lvl;
    logic       eob;
    logic       ordy;
    logic       exp_irdy;
    logic       exp_ovld;
    logic [2:0] exp_addr;
    logic       exp_err;
  } vec_t;

  vec_t vecs [13];

  rle_block_builder_if #(.COEF_W(8), .ADDR_W(15)) bus ();

  rle_block_builder #(.COEF_W(8), .ADDR_W(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.in_valid  = v.vld;
    bus.in_run    = v.run;
    bus.in_level  = v.lvl;
    bus.in_eob    = v.eob;
    bus.out_ready = v.ordy;
  endtask

  function automatic logic [511:0] packExp();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[(63-i)*8 +: 8] = exp_buf[i];
    return r;
  endfunction

  // Expected-block model: index 0 carries the DC predictor when that feature is built in.
  task automatic clearExp();
    for (int i = 0; i < 64; i++) exp_buf[i] = 8'h00;
`ifdef RLB_DC_PRED_EN
    exp_buf[0] = dc_model;
`endif
  endtask

  task automatic expWrite(input int idx, input logic [7:0] lvl);
`ifdef RLB_DC_PRED_EN
    if (idx == 0) exp_buf[0] = lvl + dc_model;
    else exp_buf[idx] = lvl;
`else
    exp_buf[idx] = lvl;
`endif
  endtask

  task automatic endBlock();
`ifdef RLB_DC_PRED_EN
    dc_model = exp_buf[0];
`endif
    clearExp();
  endtask

  task automatic sendSymbol(input logic [5:0] run, input logic [7:0] lvl, input logic eob);
    int waitCyc;
    waitCyc = 0;
    bus.in_valid = 1'b1;
    bus.in_run   = run;
    bus.in_level = lvl;
    bus.in_eob   = eob;
    while (!bus.in_ready && waitCyc < 50) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    checkOutput("sym_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_eob   = 1'b0;
  endtask

  // Drains one block; stall=1 applies the out_ready pattern 1,0,0,1,0,0,...
  task automatic drainBlock(input string name, input logic exp_err, input logic stall);
    int rows;
    logic [511:0] blk;
    blk  = packExp();
    rows = 0;
    for (int cyc = 0; cyc < 60 && rows < 8; cyc++) begin
      bus.out_ready = !stall || (cyc % 3 == 0);
      checkOutput({name, "_out_valid"}, bus.out_valid, 1'b1);
      checkOutput({name, "_in_ready"}, bus.in_ready, 1'b0);
      checkOutput({name, "_out_addr"}, bus.out_addr, 15'((rows + 4) % 8));
      checkOutput({name, "_out_err"}, bus.out_err, exp_err);
      checkOutput({name, "_blk_data"}, bus.blk_data, blk);
      if (bus.out_ready) rows++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    checkOutput({name, "_rows"}, 512'(rows), 512'd8);
    endBlock();
    checkOutput({name, "_clear_valid"}, bus.out_valid, 1'b0);
    checkOutput({name, "_clear_ready"}, bus.in_ready, 1'b0);
    checkOutput({name, "_clear_blk"}, bus.blk_data, packExp());
    @(posedge clk); #1;
    checkOutput({name, "_fill_ready"}, bus.in_ready, 1'b1);
    checkOutput({name, "_fill_err"}, bus.out_err, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    dc_model      = 8'h00;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_run    = '0;
    bus.in_level  = '0;
    bus.in_eob    = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{1'b1, 6'd0, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 6'd2, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 6'd9, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0};
    vecs[4]  = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0};
    vecs[5]  = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0};
    vecs[6]  = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0};
    vecs[7]  = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[8]  = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[9]  = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0};
    vecs[10] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0};
    vecs[11] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[12] = '{1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};

    #12;
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_addr", bus.out_addr, 15'd0);
    checkOutput("rst_out_err", bus.out_err, 1'b0);
    checkOutput("rst_blk_data", bus.blk_data, 512'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] short block with EOB, table-driven");
    clearExp();
    expWrite(0, 8'h10);
    expWrite(3, 8'h05);
    blk_a = packExp();
    endBlock();
    clr_blk = packExp();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("t1_in_ready", bus.in_ready, vecs[i].exp_irdy);
      checkOutput("t1_out_valid", bus.out_valid, vecs[i].exp_ovld);
      checkOutput("t1_out_addr", bus.out_addr, 15'(vecs[i].exp_addr));
      checkOutput("t1_out_err", bus.out_err, vecs[i].exp_err);
      if (vecs[i].exp_ovld) checkOutput("t1_blk_data", bus.blk_data, blk_a);
      else if (i >= 11) checkOutput("t1_clear_blk", bus.blk_data, clr_blk);
      @(posedge clk); #1;
    end
    applyStimulus('{1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});

    $display("[TB] full 64-symbol block without EOB");
    for (int k = 0; k < 64; k++) begin
      sendSymbol(6'd0, 8'(k), 1'b0);
      expWrite(k, 8'(k));
    end
    checkOutput("t2_drain_latency", bus.out_valid, 1'b1);
    drainBlock("t2", 1'b0, 1'b0);

    $display("[TB] overflow block then clean block");
    sendSymbol(6'd60, 8'h7F, 1'b0);
    expWrite(60, 8'h7F);
    sendSymbol(6'd5, 8'h01, 1'b0);
    checkOutput("t3_overflow_drain", bus.out_valid, 1'b1);
    drainBlock("t3_ovf", 1'b1, 1'b0);
    sendSymbol(6'd3, 8'h55, 1'b1);
    drainBlock("t3_next", 1'b0, 1'b0);

    $display("[TB] drain with out_ready stalls");
    sendSymbol(6'd7, 8'h22, 1'b0);
    expWrite(7, 8'h22);
    sendSymbol(6'd0, 8'h00, 1'b1);
    drainBlock("t4", 1'b0, 1'b1);

    $display("[TB] reset mid-fill");
    sendSymbol(6'd0, 8'h11, 1'b0);
    sendSymbol(6'd0, 8'h22, 1'b0);
    sendSymbol(6'd0, 8'h33, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_in_ready", bus.in_ready, 1'b1);
    checkOutput("t5_out_valid", bus.out_valid, 1'b0);
    checkOutput("t5_blk_data", bus.blk_data, 512'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    dc_model = 8'h00;
    clearExp();
    sendSymbol(6'd1, 8'h44, 1'b0);
    expWrite(1, 8'h44);
    sendSymbol(6'd0, 8'h00, 1'b1);
    drainBlock("t5", 1'b0, 1'b0);

`ifdef RLB_DC_PRED_EN
    $display("[TB] DC prediction");
    sendSymbol(6'd0, 8'h05, 1'b0);
    expWrite(0, 8'h05);
    sendSymbol(6'd0, 8'h00, 1'b1);
    checkOutput("t6_dc_a", bus.blk_data[511:504], 8'h05);
    drainBlock("t6a", 1'b0, 1'b0);
    sendSymbol(6'd0, 8'hFE, 1'b0);
    expWrite(0, 8'hFE);
    sendSymbol(6'd0, 8'h00, 1'b1);
    checkOutput("t6_dc_b", bus.blk_data[511:504], 8'h03);
    drainBlock("t6b", 1'b0, 1'b0);
    sendSymbol(6'd0, 8'h00, 1'b1);
    checkOutput("t6_dc_c", bus.blk_data[511:504], 8'h03);
    drainBlock("t6c", 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
